count_free_n: RTL and testbench

- Parametrised serial bit-statistics engine; successor to the fixed-width free-bit counter.
- Receives a DATA_W-bit word serially, LSB first, on start_data_i.
- Computes one of four statistics, selected per transaction by mode_i: total zeros, leading zeros (MSB side), trailing zeros (LSB side) or total ones.
- Returns the result serially and in parallel; holds it with a done/ready handshake until the consumer accepts it.

---
 rtl/count_free_n_if.sv | 26 ++
 rtl/count_free_n.sv | 126 ++++++++++++
 tb/tb_count_free_n.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/count_free_n_if.sv
// Handshake/bus bundle for the serial bit-statistics engine.
// The master side drives the word and accepts the result; the slave side is the engine.
interface count_free_n_if #(
  parameter int CNT_W = 4
);
  logic             en;
  logic             start_req_i;
  logic             start_data_i;
  logic [1:0]       mode_i;
  logic             ready_i;
  logic             result_rsp_o;
  logic             result_valid_o;
  logic [CNT_W-1:0] result_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output en, start_req_i, start_data_i, mode_i, ready_i,
    input  result_rsp_o, result_valid_o, result_o, busy_o, done_o
  );

  modport slave (
    input  en, start_req_i, start_data_i, mode_i, ready_i,
    output result_rsp_o, result_valid_o, result_o, busy_o, done_o
  );
endinterface

// File: rtl/count_free_n.sv
// Serial bit-statistics engine: takes a DATA_W-bit word LSB first, counts zeros,
// leading zeros, trailing zeros or ones, and returns the count serially and in parallel.
module count_free_n #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W+1)
) (
  input logic           clk,
  input logic           rst,
  count_free_n_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W-1);
  localparam logic [IDX_W-1:0] LAST_SEND = IDX_W'(CNT_W-1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_SEND, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             seen_q, seen_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [CNT_W-1:0] base_cnt, upd_cnt;
  logic             base_seen, upd_seen;
  logic [1:0]       cur_mode;

  // In IDLE the start bit is folded into a freshly cleared count using the live mode.
  always_comb begin
    base_cnt  = (state_q == S_IDLE) ? '0 : cnt_q;
    base_seen = (state_q == S_IDLE) ? 1'b0 : seen_q;
    cur_mode  = (state_q == S_IDLE) ? bus.mode_i : mode_q;
    upd_cnt   = base_cnt;
    upd_seen  = base_seen;
    case (cur_mode)
      2'b00: if (!bus.start_data_i) upd_cnt = base_cnt + CNT_ONE;
      2'b01: upd_cnt = bus.start_data_i ? '0 : base_cnt + CNT_ONE;
      2'b10: begin
        if (bus.start_data_i) upd_seen = 1'b1;
        else if (!base_seen)  upd_cnt  = base_cnt + CNT_ONE;
      end
      default: if (bus.start_data_i) upd_cnt = base_cnt + CNT_ONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        S_IDLE:  if (bus.start_req_i)    state_d = S_RECV;
        S_RECV:  if (idx_q == LAST_BIT)  state_d = S_SEND;
        S_SEND:  if (idx_q == LAST_SEND) state_d = S_WAIT;
        default: if (bus.ready_i)        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    idx_d  = idx_q;
    sh_d   = sh_q;
    res_d  = res_q;
    if (bus.en) begin
      case (state_q)
        S_IDLE: if (bus.start_req_i) begin
          mode_d = bus.mode_i;
          cnt_d  = upd_cnt;
          seen_d = upd_seen;
          idx_d  = IDX_ONE;
        end
        S_RECV: begin
          cnt_d  = upd_cnt;
          seen_d = upd_seen;
          if (idx_q == LAST_BIT) begin
            sh_d  = upd_cnt;
            res_d = upd_cnt;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
        S_SEND: begin
          sh_d  = sh_q >> 1;
          idx_d = (idx_q == LAST_SEND) ? '0 : idx_q + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
      idx_q  <= '0;
      sh_q   <= '0;
      res_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      res_q  <= res_d;
    end
  end

  always_comb begin
    bus.busy_o         = (state_q != S_IDLE);
    bus.done_o         = (state_q == S_WAIT);
    bus.result_valid_o = (state_q == S_SEND);
    bus.result_rsp_o   = (state_q == S_SEND) & sh_q[0];
    bus.result_o       = res_q;
  end
endmodule

// File: tb/tb_count_free_n.sv
// Randomised self-checking bench for count_free_n (DATA_W=8 and DATA_W=5 instances)
// against a loop-based statistics model.
module tb_count_free_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   last_exp = 0;

  always #5 clk = ~clk;

  count_free_n_if #(.CNT_W(4)) if8 ();
  count_free_n_if #(.CNT_W(3)) if5 ();

  count_free_n #(.DATA_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  count_free_n #(.DATA_W(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model(input logic [31:0] w, input int n, input logic [1:0] m);
    int c = 0;
    int i;
    case (m)
      2'b00: for (i = 0; i < n; i++) c += (w[i] == 1'b0) ? 1 : 0;
      2'b01: for (i = n-1; i >= 0; i--) begin
        if (w[i]) break;
        c++;
      end
      2'b10: for (i = 0; i < n; i++) begin
        if (w[i]) break;
        c++;
      end
      default: for (i = 0; i < n; i++) c += w[i] ? 1 : 0;
    endcase
    return c;
  endfunction

  // Called at the negedge after the start edge; runs until WAIT.
  // e counts enabled edges since (and including) the start edge.
  task automatic body8(input logic [7:0] w, input logic [1:0] m, input bit gate);
    int  e = 1;
    int  steps = 0;
    bit  en_now;
    last_exp = model({24'd0, w}, 8, m);
    if8.start_req_i = 1'b0;
    if8.mode_i      = ~m;
    while (e < 12 && steps < 100) begin
      check("busy", if8.busy_o, 1);
      check("done_early", if8.done_o, 0);
      if (e < 8) check("valid_recv", if8.result_valid_o, 0);
      else begin
        check("valid_send", if8.result_valid_o, 1);
        check("rsp", if8.result_rsp_o, (last_exp >> (e-8)) & 1);
        check("res_send", if8.result_o, last_exp);
      end
      en_now = !(gate && ((steps >= 2 && steps <= 4) || (steps >= 10 && steps <= 12)));
      if8.en           = en_now;
      if8.start_data_i = (e < 8) ? w[e] : 1'($urandom);
      if8.start_req_i  = 1'($urandom);
      if8.ready_i      = 1'($urandom);
      if8.mode_i       = 2'($urandom);
      @(negedge clk);
      steps++;
      if (en_now) e++;
    end
    if8.en = 1'b1; if8.start_req_i = 1'b0; if8.ready_i = 1'b0;
    check("lat_wait", steps, gate ? 17 : 11);
    check("done", if8.done_o, 1);
    check("busy_wait", if8.busy_o, 1);
    check("valid_wait", if8.result_valid_o, 0);
    check("res_wait", if8.result_o, last_exp);
  endtask

  task automatic go8(input logic [7:0] w, input logic [1:0] m, input bit gate);
    @(negedge clk);
    if8.en = 1'b1; if8.ready_i = 1'b0;
    if8.start_req_i = 1'b1; if8.mode_i = m; if8.start_data_i = w[0];
    @(negedge clk);
    body8(w, m, gate);
  endtask

  // In WAIT: stall, then release; optionally keep start high through the release.
  task automatic finish8(input int hold, input bit restart, input logic [7:0] nw,
                         input logic [1:0] nm, input bit gate);
    for (int i = 0; i < hold; i++) begin
      if8.ready_i = 1'b0; if8.start_req_i = 1'(i);
      @(negedge clk);
      check("hold_done", if8.done_o, 1);
      check("hold_res", if8.result_o, last_exp);
    end
    if8.ready_i = 1'b1; if8.start_req_i = restart;
    if8.mode_i = nm; if8.start_data_i = nw[0];
    @(negedge clk);
    if8.ready_i = 1'b0;
    check("idle_busy", if8.busy_o, 0);
    check("idle_done", if8.done_o, 0);
    check("idle_res", if8.result_o, last_exp);
    if (restart) begin
      @(negedge clk);
      check("restart_busy", if8.busy_o, 1);
      body8(nw, nm, gate);
    end else begin
      if8.start_req_i = 1'b0;
    end
  endtask

  task automatic go5(input logic [4:0] w, input logic [1:0] m);
    int exp5 = model({27'd0, w}, 5, m);
    @(negedge clk);
    if5.en = 1'b1; if5.start_req_i = 1'b1; if5.mode_i = m; if5.start_data_i = w[0];
    @(negedge clk);
    if5.start_req_i = 1'b0;
    for (int e = 1; e < 5; e++) begin
      check("b5_busy", if5.busy_o, 1);
      check("b5_valid_recv", if5.result_valid_o, 0);
      if5.start_data_i = w[e];
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      check("b5_valid", if5.result_valid_o, 1);
      check("b5_rsp", if5.result_rsp_o, (exp5 >> k) & 1);
      @(negedge clk);
    end
    check("b5_done", if5.done_o, 1);
    check("b5_valid_end", if5.result_valid_o, 0);
    check("b5_res", if5.result_o, exp5);
    if5.ready_i = 1'b1;
    @(negedge clk);
    if5.ready_i = 1'b0;
    check("b5_idle", if5.busy_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    if8.en = 1'b1; if8.start_req_i = 1'b0; if8.start_data_i = 1'b0; if8.mode_i = 2'b00; if8.ready_i = 1'b0;
    if5.en = 1'b1; if5.start_req_i = 1'b0; if5.start_data_i = 1'b0; if5.mode_i = 2'b00; if5.ready_i = 1'b0;
    #1;
    check("rst_busy", if8.busy_o, 0);
    check("rst_done", if8.done_o, 0);
    check("rst_valid", if8.result_valid_o, 0);
    check("rst_rsp", if8.result_rsp_o, 0);
    check("rst_res", if8.result_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed words in every mode, including the all-zero word
    go8(8'b1011_0010, 2'b00, 1'b0); check("m00", if8.result_o, 4); finish8(0, 0, 8'h00, 2'b00, 0);
    go8(8'b1011_0010, 2'b01, 1'b0); check("m01", if8.result_o, 0); finish8(1, 0, 8'h00, 2'b00, 0);
    go8(8'b1011_0010, 2'b10, 1'b0); check("m10", if8.result_o, 1); finish8(0, 0, 8'h00, 2'b00, 0);
    go8(8'b1011_0010, 2'b11, 1'b0); check("m11", if8.result_o, 4); finish8(0, 0, 8'h00, 2'b00, 0);
    go8(8'h00, 2'b01, 1'b0);        check("lz_full", if8.result_o, 8); finish8(0, 0, 8'h00, 2'b00, 0);

    // Asynchronous reset in the middle of RECV
    @(negedge clk);
    if8.start_req_i = 1'b1; if8.mode_i = 2'b11; if8.start_data_i = 1'b1;
    @(negedge clk); if8.start_req_i = 1'b0; if8.start_data_i = 1'b1;
    @(negedge clk); if8.start_data_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", if8.busy_o, 0);
    check("arst_done", if8.done_o, 0);
    check("arst_valid", if8.result_valid_o, 0);
    check("arst_rsp", if8.result_rsp_o, 0);
    check("arst_res", if8.result_o, 0);
    rst = 1'b0;
    go8(8'b1011_0010, 2'b00, 1'b0); check("post_rst", if8.result_o, 4); finish8(0, 0, 8'h00, 2'b00, 0);

    // Clock-enable gaps in RECV and SEND
    go8(8'b1011_0010, 2'b00, 1'b1); check("gated", if8.result_o, 4);

    // Long stall in WAIT, then release with start held and a new mode
    finish8(20, 1, 8'b0001_0000, 2'b10, 1'b0);
    check("chained", if8.result_o, 4);
    finish8(0, 0, 8'h00, 2'b00, 0);

    // Randomised transactions
    for (int t = 0; t < 40; t++) begin
      logic [7:0] w  = 8'($urandom);
      logic [1:0] m  = 2'($urandom);
      logic [7:0] nw = 8'($urandom);
      logic [1:0] nm = 2'($urandom);
      go8(w, m, 1'($urandom));
      finish8($urandom_range(0, 3), 1'($urandom), nw, nm, 1'($urandom));
      if (if8.busy_o) finish8($urandom_range(0, 2), 1'b0, 8'h00, 2'b00, 1'b0);
    end

    // Narrow instance
    go5(5'b10000, 2'b10);
    for (int t = 0; t < 8; t++) go5(5'($urandom), 2'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
